// File: rtl/nn_pkg.sv
// Shared FSM state type and bank/address sizing helpers for the NN input ping-pong buffer.
package nn_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } nn_state_e;

    localparam int NUM_BANKS = 2;

    // Never returns 0 so that degenerate 1-pixel dimensions still give a legal port width.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bank_depth(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/nn_bank_ram.sv
// One image bank: simple dual-port RAM, synchronous write, registered read.
// Reads beyond DEPTH return zero.
module nn_bank_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                     rdata_q <= '0;
        else if (32'(raddr_i) < 32'(DEPTH)) rdata_q <= mem_q[raddr_i];
        else                              rdata_q <= '0;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nn_input_pingpong.sv
// Ping-pong frame buffer between pixel capture and an HLS-style NN core.
// Define NN_WATCHDOG_EN to add a handshake watchdog that aborts a stuck NN run.
//
// state   | meaning
// S_IDLE  | no NN run; frame_end swaps banks and marks the read bank ready
// S_START | nn_start held high until the core drops nn_idle
// S_RUN   | core busy on the read bank; frame_end here counts as a drop
module nn_input_pingpong
    import nn_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 2**20
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic [PIX_W-1:0]                    pix_data,
    input  logic [width_of(IMG_W)-1:0]          pix_x,
    input  logic [width_of(IMG_H)-1:0]          pix_y,
    input  logic                                pix_en,
    input  logic                                frame_end,
    input  logic                                cfg_auto,
    input  logic                                cfg_start,
    output logic                                nn_start,
    input  logic                                nn_idle,
    input  logic [width_of(IMG_W*IMG_H)-1:0]    nn_raddr,
    output logic [PIX_W-1:0]                    nn_rdata,
    input  logic [RES_W-1:0]                    nn_result,
    input  logic                                nn_result_vld,
    output logic [RES_W-1:0]                    res_data,
    output logic                                res_en,
    output logic                                busy,
    output logic [15:0]                         drop_cnt,
    output logic                                timeout_flag
);

    localparam int NPIX = bank_depth(IMG_W, IMG_H);
    localparam int AW   = width_of(NPIX);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    nn_state_e         state_q;
    logic              wb_q;
    logic              ready_q;
    logic              start_pend_q;
    logic              nn_start_q;
    logic              res_en_q;
    logic [RES_W-1:0]  res_data_q;
    logic [15:0]       drop_cnt_q;
    logic              rd_sel_q;

`ifdef NN_WATCHDOG_EN
    localparam int WDW = width_of(TIMEOUT);
    logic [WDW-1:0]    wd_cnt_q;
    logic              timeout_q;
`endif

    logic              pix_ok;
    logic [AW-1:0]     waddr;
    logic [PIX_W-1:0]  rdata0, rdata1;
    logic              go;
    logic [15:0]       drop_sat;

    assign pix_ok = pix_en && (32'(pix_x) < 32'(IMG_W)) && (32'(pix_y) < 32'(IMG_H));
    assign waddr  = AW'(32'(pix_y) * 32'(IMG_W) + 32'(pix_x));

    nn_bank_ram #(.DW(PIX_W), .DEPTH(NPIX), .AW(AW)) u_bank0 (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .we_i    (pix_ok && !wb_q),
        .waddr_i (waddr),
        .wdata_i (pix_data),
        .raddr_i (nn_raddr),
        .rdata_o (rdata0)
    );

    nn_bank_ram #(.DW(PIX_W), .DEPTH(NPIX), .AW(AW)) u_bank1 (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .we_i    (pix_ok && wb_q),
        .waddr_i (waddr),
        .wdata_i (pix_data),
        .raddr_i (nn_raddr),
        .rdata_o (rdata1)
    );

    assign go       = (state_q == S_IDLE) && ready_q && (cfg_auto || start_pend_q) && nn_idle;
    assign drop_sat = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            wb_q         <= 1'b0;
            ready_q      <= 1'b0;
            start_pend_q <= 1'b0;
            nn_start_q   <= 1'b0;
            res_en_q     <= 1'b0;
            res_data_q   <= '0;
            drop_cnt_q   <= '0;
            rd_sel_q     <= 1'b0;
`ifdef NN_WATCHDOG_EN
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            res_en_q <= 1'b0;
            // The read data register belongs to whichever bank was the read bank at sample time.
            rd_sel_q <= ~wb_q;
            case (state_q)
                S_IDLE: begin
                    if (frame_end) begin
                        wb_q    <= ~wb_q;
                        ready_q <= 1'b1;
                    end
                    if (go) begin
                        state_q      <= S_START;
                        nn_start_q   <= 1'b1;
                        start_pend_q <= 1'b0;
`ifdef NN_WATCHDOG_EN
                        wd_cnt_q     <= WDW'(TIMEOUT - 1);
`endif
                    end else if (cfg_start) begin
                        start_pend_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (frame_end) drop_cnt_q <= drop_sat;
                    if (!nn_idle) begin
                        state_q    <= S_RUN;
                        nn_start_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (nn_result_vld) begin
                        res_data_q <= nn_result;
                        res_en_q   <= 1'b1;
                        state_q    <= S_IDLE;
                        // The read bank is released this cycle, so a coincident frame swaps in.
                        ready_q    <= frame_end;
                        if (frame_end) wb_q <= ~wb_q;
                    end else if (frame_end) begin
                        drop_cnt_q <= drop_sat;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef NN_WATCHDOG_EN
            if ((state_q != S_IDLE) && !((state_q == S_RUN) && nn_result_vld)) begin
                if (wd_cnt_q == '0) begin
                    state_q    <= S_IDLE;
                    nn_start_q <= 1'b0;
                    ready_q    <= 1'b0;
                    timeout_q  <= 1'b1;
                end else begin
                    wd_cnt_q <= wd_cnt_q - 1'b1;
                end
            end
`endif
        end
    end

    assign nn_start = nn_start_q;
    assign res_en   = res_en_q;
    assign res_data = res_data_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != S_IDLE);
    assign nn_rdata = rd_sel_q ? rdata1 : rdata0;

`ifdef NN_WATCHDOG_EN
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_nn_input_pingpong.sv
// Bench for nn_input_pingpong: directed bank/handshake sequences, a read-address table,
// and random traffic checked against a transaction-level model of the buffer.
module tb_nn_input_pingpong;

    localparam int PIX_W = 8;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int RES_W = 32;
    localparam int TMO   = 64;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef NN_WATCHDOG_EN
    localparam int AUTO_LAT = 40;
    localparam int AUTO_PER = 20;
`else
    localparam int AUTO_LAT = 100;
    localparam int AUTO_PER = 50;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [7:0]       pix_data;
    logic [4:0]       pix_x, pix_y;
    logic             pix_en, frame_end, cfg_auto, cfg_start;
    logic             nn_start, nn_idle;
    logic [9:0]       nn_raddr;
    logic [7:0]       nn_rdata;
    logic [31:0]      nn_result;
    logic             nn_result_vld;
    logic [31:0]      res_data;
    logic             res_en, busy;
    logic [15:0]      drop_cnt;
    logic             timeout_flag;

    always #5 CLK = ~CLK;

    nn_input_pingpong #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .RES_W(RES_W), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_en(pix_en),
        .frame_end(frame_end), .cfg_auto(cfg_auto), .cfg_start(cfg_start),
        .nn_start(nn_start), .nn_idle(nn_idle), .nn_raddr(nn_raddr), .nn_rdata(nn_rdata),
        .nn_result(nn_result), .nn_result_vld(nn_result_vld),
        .res_data(res_data), .res_en(res_en), .busy(busy),
        .drop_cnt(drop_cnt), .timeout_flag(timeout_flag)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_defaults();
        pix_data = '0; pix_x = '0; pix_y = '0; pix_en = 1'b0;
        frame_end = 1'b0; cfg_auto = 1'b0; cfg_start = 1'b0;
        nn_idle = 1'b1; nn_raddr = '0; nn_result = '0; nn_result_vld = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_nn_start"}, 64'(nn_start), 64'(0));
        chk({tag, "_res_en"}, 64'(res_en), 64'(0));
        chk({tag, "_res_data"}, 64'(res_data), 64'(0));
        chk({tag, "_nn_rdata"}, 64'(nn_rdata), 64'(0));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout_flag), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        set_defaults();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic write_frame(input bit invert);
        for (int a = 0; a < NPIX; a++) begin
            pix_en   = 1'b1;
            pix_x    = 5'(a % IMG_W);
            pix_y    = 5'(a / IMG_W);
            pix_data = invert ? ~8'(a) : 8'(a);
            tick();
        end
        pix_en = 1'b0;
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    endtask

    task automatic wait_start(input string name, input int lim);
        int n = 0;
        while (nn_start !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk(name, 64'(nn_start), 64'(1));
    endtask

    // Read-port vectors against a frame written with value = addr[7:0]
    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t rtab [6];

    task automatic read_table(input string tag, input logic [7:0] prev_in);
        logic [7:0] prev;
        prev = prev_in;
        for (int i = 0; i < 6; i++) begin
            nn_raddr = rtab[i].addr;
            #1;
            chk({tag, "_hold"}, 64'(nn_rdata), 64'(prev));
            tick();
            chk({tag, "_rd"}, 64'(nn_rdata), 64'(rtab[i].exp));
            prev = rtab[i].exp;
        end
    endtask

    // Transaction-level reference: two frame stores, a pending-frame flag, and an NN job flag
    logic [7:0] m_mem [2][NPIX];
    bit         m_val [2][NPIX];
    bit         m_wb, m_ready, m_pend, m_active, m_acked, m_resen, m_rknown;
    int         m_drop;
    logic [7:0] m_rdata;
    logic [31:0] m_resdata;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NPIX; a++) m_val[b][a] = 1'b0;
        m_wb = 0; m_ready = 0; m_pend = 0; m_active = 0; m_acked = 0;
        m_resen = 0; m_rknown = 0; m_drop = 0; m_rdata = '0; m_resdata = '0;
    endtask

    task automatic model_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_step();
        bit go;
        int wa;
        go = !m_active && m_ready && (cfg_auto || m_pend) && nn_idle;
        m_rknown = m_val[!m_wb][nn_raddr];
        m_rdata  = m_mem[!m_wb][nn_raddr];
        if (pix_en) begin
            wa = int'(pix_y) * IMG_W + int'(pix_x);
            m_mem[m_wb][wa] = pix_data;
            m_val[m_wb][wa] = 1'b1;
        end
        m_resen = 0;
        if (!m_active) begin
            if (frame_end) begin m_wb = !m_wb; m_ready = 1; end
            if (go) begin m_active = 1; m_acked = 0; m_pend = 0; end
            else if (cfg_start) m_pend = 1;
        end else if (!m_acked) begin
            if (frame_end) model_drop();
            if (!nn_idle) m_acked = 1;
        end else if (nn_result_vld) begin
            m_resen = 1; m_resdata = nn_result; m_active = 0;
            m_ready = frame_end;
            if (frame_end) m_wb = !m_wb;
        end else if (frame_end) begin
            model_drop();
        end
    endtask

    task automatic model_check();
        chk("busy", 64'(busy), 64'(m_active));
        chk("nn_start", 64'(nn_start), 64'(m_active && !m_acked));
        chk("res_en", 64'(res_en), 64'(m_resen));
        if (m_resen) chk("res_data", 64'(res_data), 64'(m_resdata));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_rknown) chk("nn_rdata", 64'(nn_rdata), 64'(m_rdata));
    endtask

    // Fake NN core: acknowledges nn_start after 0-2 cycles, returns a result after lat cycles
    int nn_ph = 0, nn_cnt = 0, nn_ackd = 0;

    task automatic run_traffic(input int ncyc, input bit auto_mode, input int fe_per,
                               input int lat, output int nres);
        nres = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            cfg_auto  = auto_mode;
            pix_en    = 1'($urandom_range(0, 1));
            pix_x     = 5'($urandom);
            pix_y     = 5'($urandom);
            pix_data  = 8'($urandom);
            nn_raddr  = 10'($urandom);
            frame_end = (fe_per > 0) ? (c % fe_per == fe_per - 1) : ($urandom_range(0, 39) == 0);
            cfg_start = !auto_mode && ($urandom_range(0, 29) == 0);
            nn_result_vld = 1'b0;
            if (nn_ph == 0) begin
                nn_idle = 1'b1;
                if (nn_start) begin
                    if (nn_ackd == 0) begin
                        nn_idle = 1'b0;
                        nn_ph   = 1;
                        nn_cnt  = (lat > 0) ? lat : int'($urandom_range(1, 30));
                    end else begin
                        nn_ackd--;
                    end
                end else begin
                    nn_ackd = int'($urandom_range(0, 2));
                end
            end else begin
                nn_idle = 1'b0;
                if (nn_cnt == 0) begin
                    nn_result_vld = 1'b1;
                    nn_result     = $urandom;
                    nn_ph         = 0;
                end else begin
                    nn_cnt--;
                end
            end
            @(posedge CLK);
            model_step();
            #1;
            model_check();
            if (res_en) nres++;
        end
        @(negedge CLK);
        set_defaults();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int  bc;
        bit  sawres;
        int  nres;

        rtab[0] = '{10'd5,    8'h05};
        rtab[1] = '{10'd0,    8'h00};
        rtab[2] = '{10'd255,  8'hFF};
        rtab[3] = '{10'd256,  8'h00};
        rtab[4] = '{10'd1023, 8'hFF};
        rtab[5] = '{10'd700,  8'hBC};

        set_defaults();
        RST_N = 1'b0;
        #3;
        chk_zero("reset");
        tick(); tick();
        RST_N = 1'b1;
        tick();

        // First frame, start, reads while nn_start is still up
        write_frame(1'b0);
        pulse_fe();
        pulse_start();
        wait_start("first_start", 10);
        chk("first_busy", 64'(busy), 64'(1));
        read_table("frame1", 8'h00);
        chk("start_held", 64'(nn_start), 64'(1));
        nn_idle = 1'b0;
        tick();
        chk("start_released", 64'(nn_start), 64'(0));
        chk("run_busy", 64'(busy), 64'(1));

        // Frames arriving while the NN runs are dropped and do not disturb the read bank
        write_frame(1'b1);
        repeat (3) begin pulse_fe(); tick(); end
        chk("drops_3", 64'(drop_cnt), 64'(3));
        read_table("frame1_kept", 8'hBC);

        nn_result = 32'd7; nn_result_vld = 1'b1;
        tick();
        nn_result_vld = 1'b0; nn_idle = 1'b1;
        chk("res7_en", 64'(res_en), 64'(1));
        chk("res7_data", 64'(res_data), 64'(7));
        chk("res7_idle", 64'(busy), 64'(0));
        tick();
        chk("res_en_one_cycle", 64'(res_en), 64'(0));
        chk("res_data_held", 64'(res_data), 64'(7));

        // frame_end coincident with nn_result_vld swaps without a drop
        pulse_fe();
        pulse_start();
        wait_start("second_start", 10);
        nn_raddr = 10'd5;
        tick();
        chk("frame2_rd", 64'(nn_rdata), 64'(8'hFA));
        nn_idle = 1'b0;
        tick();
        frame_end = 1'b1; nn_result_vld = 1'b1; nn_result = 32'h0000_A5A5;
        tick();
        frame_end = 1'b0; nn_result_vld = 1'b0; nn_idle = 1'b1;
        chk("coinc_res_en", 64'(res_en), 64'(1));
        chk("coinc_res_data", 64'(res_data), 64'(32'h0000_A5A5));
        chk("coinc_no_drop", 64'(drop_cnt), 64'(3));
        chk("coinc_idle", 64'(busy), 64'(0));
        tick();
        chk("coinc_swapped_rd", 64'(nn_rdata), 64'(8'h05));
        pulse_start();
        wait_start("coinc_ready", 10);

        // cfg_start during a run must not leave a pending start behind
        nn_idle = 1'b0;
        tick();
        pulse_start();
        nn_result_vld = 1'b1;
        tick();
        nn_result_vld = 1'b0; nn_idle = 1'b1;
        pulse_fe();
        repeat (4) tick();
        chk("start_ignored_in_run", 64'(busy), 64'(0));

        // nn_idle stuck high: watchdog abort, or indefinite wait without it
        pulse_fe();
        pulse_start();
        bc = 0; sawres = 0;
        for (int n = 0; n < 150; n++) begin
            tick();
            if (res_en) sawres = 1;
            if (busy) bc++;
            else if (bc > 0) break;
        end
`ifdef NN_WATCHDOG_EN
        chk("wd_busy_cycles", 64'(bc), 64'(TMO));
        chk("wd_flag", 64'(timeout_flag), 64'(1));
        chk("wd_idle", 64'(busy), 64'(0));
`else
        chk("nowd_still_busy", 64'(busy), 64'(1));
        chk("nowd_flag", 64'(timeout_flag), 64'(0));
`endif
        chk("wd_no_res", 64'(sawres), 64'(0));

        // Reset pulse in the middle of a run
        do_reset();
        pulse_fe();
        pulse_start();
        wait_start("pre_reset_start", 10);
        nn_idle = 1'b0;
        tick();
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #2;
        RST_N = 1'b0;
        #1;
        chk_zero("midrun_reset");
        tick();
        RST_N = 1'b1;
        nn_result_vld = 1'b1; nn_result = 32'd99;
        sawres = 0;
        repeat (3) begin tick(); if (res_en) sawres = 1; end
        chk("no_res_after_reset", 64'(sawres), 64'(0));
        set_defaults();

        // Random traffic against the reference model
        do_reset();
        model_reset();
        nn_ph = 0; nn_ackd = 0;
        run_traffic(3000, 1'b0, 0, 0, nres);
        run_traffic(1500, 1'b1, 0, 0, nres);

        // Continuous mode with frames faster than the NN
        do_reset();
        model_reset();
        nn_ph = 0; nn_ackd = 0;
        run_traffic(1000, 1'b1, AUTO_PER, AUTO_LAT, nres);
        chk("auto_results", 64'(nres >= 4), 64'(1));
        chk("auto_drops", 64'(drop_cnt >= 16'd4), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
